// File: rtl/btn_irq_ctrl.sv
// Debounced button interrupt controller with an AXI4-Lite register slave.
// Each channel is synchronized, debounced, edge-detected and latched into a sticky ISR.

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        // The count of stable differing cycles completes on the increment that
        // would reach DEBOUNCE_CYCLES, so the toggle lands in that same cycle.
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                state_d = ~state_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = state_q;
    assign rise  = state_d & ~state_q;
    assign fall  = ~state_d & state_q;

endmodule

module btn_irq_ctrl #(
    parameter int NUM_BTN            = 4,
    parameter int DEBOUNCE_CYCLES    = 1000,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [NUM_BTN-1:0]            btn_in,
    output logic                          irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_STATE = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_IER   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ISR   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_EDGE  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_GIE   = IDX_W'(4);

    logic               clk, rst_n;
    logic [NUM_BTN-1:0] level, rise, fall, evt;

    logic [NUM_BTN-1:0] ier_q, ier_d;
    logic [NUM_BTN-1:0] isr_q, isr_d;
    logic [NUM_BTN-1:0] edge_q, edge_d;
    logic               gie_q, gie_d;
    logic               irq_q, irq_d;

    logic               awready_q, awready_d;
    logic               bvalid_q, bvalid_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               wr_en, rd_en;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [NUM_BTN-1:0] wbits, wdat, w1c;
    logic [31:0]        rd_word;
    logic               unused_bits;

    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_in[g]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    // Address and data both qualify the handshake, so neither is ever captured alone.
    assign wr_en  = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en  = arready_q & s00_axi_arvalid;
    assign wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            wbits[i] = s00_axi_wstrb[i / 8];
            wdat[i]  = s00_axi_wdata[i];
        end
    end

    always_comb begin
        ier_d  = ier_q;
        edge_d = edge_q;
        gie_d  = gie_q;
        w1c    = '0;
        if (wr_en) begin
            case (wr_idx)
                IDX_IER:  ier_d  = (ier_q & ~wbits) | (wdat & wbits);
                IDX_ISR:  w1c    = wdat & wbits;
                IDX_EDGE: edge_d = (edge_q & ~wbits) | (wdat & wbits);
                IDX_GIE:  if (s00_axi_wstrb[0]) gie_d = s00_axi_wdata[0];
                default:  ;
            endcase
        end
        evt   = (rise & ~edge_q) | (fall & edge_q);
        // A new event outranks a same-cycle clear so no edge is lost.
        isr_d = (isr_q & ~w1c) | evt;
        irq_d = gie_q & (|(isr_q & ier_q));
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            IDX_STATE: rd_word[NUM_BTN-1:0] = level;
            IDX_IER:   rd_word[NUM_BTN-1:0] = ier_q;
            IDX_ISR:   rd_word[NUM_BTN-1:0] = isr_q;
            IDX_EDGE:  rd_word[NUM_BTN-1:0] = edge_q;
            IDX_GIE:   rd_word[0]           = gie_q;
            default:   rd_word = '0;
        endcase
    end

    always_comb begin
        awready_d = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        arready_d = s00_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ier_q     <= '0;
            isr_q     <= '0;
            edge_q    <= '0;
            gie_q     <= 1'b0;
            irq_q     <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ier_q     <= ier_d;
            isr_q     <= isr_d;
            edge_q    <= edge_d;
            gie_q     <= gie_d;
            irq_q     <= irq_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign irq             = irq_q;
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;

    // Byte-offset address bits and data/strobe bits above NUM_BTN carry no state.
    assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_wdata, s00_axi_wstrb};

endmodule

// File: doc/btn_irq_ctrl.md
BTN_IRQ_CTRL -- requirements
Module: btn_irq_ctrl

Interface
REQ-001 Parameter NUM_BTN, default 4: number of button channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required to accept a level change, minimum 1.
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 5: AXI4-Lite byte address width; data width is fixed at 32.
REQ-004 s00_axi_aclk  in  1  single clock for all logic.
REQ-005 s00_axi_aresetn  in  1  asynchronous active-low reset.
REQ-006 btn_in  in  NUM_BTN  raw active-high buttons, asynchronous to the clock.
REQ-007 irq  out  1  registered level interrupt, active-high.
REQ-008 s00_axi_awaddr in C_S_AXI_ADDR_WIDTH; s00_axi_awvalid in 1; s00_axi_awready out 1: write address channel.
REQ-009 s00_axi_wdata in 32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1: write data channel.
REQ-010 s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1: write response channel.
REQ-011 s00_axi_araddr in C_S_AXI_ADDR_WIDTH; s00_axi_arvalid in 1; s00_axi_arready out 1: read address channel.
REQ-012 s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1: read data channel.

Function
REQ-013 Register map SHALL be: 0x00 STATE (RO, debounced levels); 0x04 IER (RW, per-channel enable); 0x08 ISR (W1C, sticky pending); 0x0C EDGE (RW, 0 = rising, 1 = falling); 0x10 GIE (RW, bit0 only).
REQ-014 Bits at or above NUM_BTN SHALL read 0 and ignore writes; unmapped addresses SHALL read 0 and ignore writes; all responses SHALL be OKAY (2'b00).
REQ-015 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Each channel SHALL have a counter of width clog2(DEBOUNCE_CYCLES+1) that increments while the synced input differs from STATE and clears when they match.
REQ-017 STATE bit SHALL toggle, and its counter clear, in the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-018 A channel event SHALL fire for one cycle on a STATE 0->1 change when EDGE=0, or a 1->0 change when EDGE=1.
REQ-019 An event SHALL set its ISR bit whatever the IER value; if the event and a W1C of the same bit occur in one cycle, set SHALL win.
REQ-020 irq SHALL be registered as GIE & |(ISR & IER), so it follows the causing condition by one cycle.
REQ-021 Write path SHALL assert awready and wready together for one cycle only when awvalid, wvalid and !bvalid all hold; the register update SHALL occur in that same cycle.
REQ-022 bvalid SHALL rise the cycle after the handshake and stay high until bready is sampled high.
REQ-023 A write waiting on one of awvalid/wvalid SHALL stall with no partial capture.
REQ-024 wstrb SHALL qualify each byte for IER, EDGE and GIE writes, and for the ISR W1C mask.
REQ-025 Read path SHALL assert arready for one cycle when arvalid && !rvalid, register rdata, and raise rvalid the next cycle.
REQ-026 rvalid and rdata SHALL hold stable until rready is sampled high.
REQ-027 Read and write channels SHALL operate independently; a same-cycle read of a register being written SHALL return the pre-write value.

Reset
REQ-028 While s00_axi_aresetn is low, all registers, synchronizers, counters, STATE, irq, awready, wready, bvalid, arready and rvalid SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-transaction SHALL abort it with no register update; the first handshake after release SHALL be a new transaction.
REQ-030 A button held high through reset release SHALL set STATE DEBOUNCE_CYCLES+2 cycles after release and SHALL generate a rising event.

Verification (NUM_BTN=4, DEBOUNCE_CYCLES=4)
REQ-031 Write IER=0xF and GIE=1, then hold btn_in[0] high for 10 cycles -> STATE=0x1, ISR=0x1, and irq high 1 cycle after the ISR bit sets.
REQ-032 Toggle btn_in[1] every 2 cycles for 20 cycles -> STATE, ISR and irq all stay 0.
REQ-033 Write EDGE=0x4, then press and release btn_in[2] -> ISR[2] sets only after the release is debounced.
REQ-034 With ISR=0x1 and IER=0, write GIE=1 -> irq stays 0; then write IER=0x1 -> irq goes 1; then write ISR=0x1 -> ISR=0 and irq returns to 0.
REQ-035 Hold bready low for 5 cycles after a write -> bvalid stays high and awready stays low; read 0x14 -> 0x00000000, OKAY.
REQ-036 Drive a W1C on ISR[3] in the same cycle a btn_in[3] rising event fires -> ISR[3] remains 1.
